// File: rtl/sky130_sram_1rw1r_param_model_if.sv
// Port bundle for sky130_sram_1rw1r_param_model.
// Carries the port 0 read/write bus, the port 1 read bus and the status
// flags. Clock and reset are plain module ports, not part of the bundle.
// The master modport is the side that issues accesses; the slave modport
// is the SRAM model itself.
interface sky130_sram_1rw1r_param_model_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int ADDR_WIDTH = 10
);
   // Port 0: read/write
   logic                  csb0;
   logic                  web0;
   logic [NUM_WMASKS-1:0] wmask0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;

   // Port 1: read only
   logic                  csb1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] dout1;

   // Status
   logic                  init_done;
   logic                  collision;

   modport master (
      output csb0, web0, wmask0, addr0, din0,
      output csb1, addr1,
      input  dout0, dout1, init_done, collision
   );

   modport slave (
      input  csb0, web0, wmask0, addr0, din0,
      input  csb1, addr1,
      output dout0, dout1, init_done, collision
   );
endinterface

// File: rtl/sky130_sram_1rw1r_param_model.sv
// sky130_sram_1rw1r_param_model
// Parametrised behavioural model of a 1RW + 1R SRAM on a single clock.
// - Port 0 reads or writes, with per-lane write masking. Port 1 is read-only.
// - After reset, an INIT sweep writes zero to every implemented word, one
//   word per cycle. Both ports are ignored until the sweep completes.
// - Addresses at or above RAM_DEPTH are unimplemented: writes are dropped,
//   reads return zero, and they never raise collision.
// - collision pulses for one cycle after a port 1 read hits the word that
//   port 0 wrote on the same edge.
// Optional feature macro: SRAM_BYPASS_EN. When it is defined, a colliding
// port 1 read returns the freshly merged write word. When it is undefined,
// the read returns the old contents of the word (read-before-write).
module sky130_sram_1rw1r_param_model #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input logic                           clk0,
   input logic                           rst0,
   sky130_sram_1rw1r_param_model_if.slave sram
);

   localparam int                    LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;
   // One bit wider than an address, so the value 1<<ADDR_WIDTH fits.
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_DEPTH - 1);

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_init_addr;
   logic [ADDR_WIDTH-1:0] w_init_addr_nxt;

   logic [DATA_WIDTH-1:0] r_mem [0:RAM_DEPTH-1];

   logic [DATA_WIDTH-1:0] r_dout0;
   logic [DATA_WIDTH-1:0] r_dout1;
   logic                  r_collision;

   logic                  w_ready;
   logic                  w_wr0;
   logic                  w_rd0;
   logic                  w_rd1;
   logic                  w_addr0_ok;
   logic                  w_addr1_ok;
   logic [DATA_WIDTH-1:0] w_mem0;
   logic [DATA_WIDTH-1:0] w_mem1;
   logic [DATA_WIDTH-1:0] w_merged;
   logic [DATA_WIDTH-1:0] w_rd1_data;
   logic                  w_collision;

   // Access qualification. Both ports are gated off until the sweep is done.
   assign w_ready    = (r_state == ST_READY);
   assign w_wr0      = w_ready & ~sram.csb0 & ~sram.web0;
   assign w_rd0      = w_ready & ~sram.csb0 &  sram.web0;
   assign w_rd1      = w_ready & ~sram.csb1;
   assign w_addr0_ok = ({1'b0, sram.addr0} < DEPTH_EXT);
   assign w_addr1_ok = ({1'b0, sram.addr1} < DEPTH_EXT);

   // Array read data. Unimplemented addresses read as zero.
   assign w_mem0 = w_addr0_ok ? r_mem[sram.addr0] : '0;
   assign w_mem1 = w_addr1_ok ? r_mem[sram.addr1] : '0;

   // A port 1 read of the word that port 0 is writing, within the implemented range.
   assign w_collision = w_wr0 & w_rd1 & w_addr0_ok & (sram.addr0 == sram.addr1);

   // Merged write word: enabled lanes come from din0, the rest keep the old contents.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' and assigns a default first.
      // Every path then drives the signal, so no latch is inferred.
      w_merged = w_mem0;
      for (int i = 0; i < NUM_WMASKS; i++) begin
         if (sram.wmask0[i]) begin
            w_merged[i*LANE_WIDTH +: LANE_WIDTH] = sram.din0[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   // Port 1 data source: old contents, or the merged word on a collision.
   always_comb begin
      w_rd1_data = w_mem1;
`ifdef SRAM_BYPASS_EN
      if (w_collision) begin
         w_rd1_data = w_merged;
      end
`endif
   end

   // FSM state and sweep counter register.
   always_ff @(posedge clk0 or posedge rst0) begin
      // NOTE: sequential state uses non-blocking '<=' so that every flop
      // samples values from before the edge, whatever the statement order.
      if (rst0) begin
         r_state     <= ST_INIT;
         r_init_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_addr <= w_init_addr_nxt;
      end
   end

   // FSM next state: sweep addresses 0..RAM_DEPTH-1, then stay READY.
   always_comb begin
      w_state_nxt     = r_state;
      w_init_addr_nxt = r_init_addr;
      case (r_state)
         ST_INIT: begin
            if (r_init_addr == LAST_ADDR) begin
               w_state_nxt     = ST_READY;
               w_init_addr_nxt = '0;
            end else begin
               w_init_addr_nxt = r_init_addr + 1'b1;
            end
         end
         ST_READY: begin
            w_state_nxt = ST_READY;
         end
         default: begin
            w_state_nxt     = ST_INIT;
            w_init_addr_nxt = '0;
         end
      endcase
   end

   // Array write port: the zero sweep during INIT, masked port 0 writes in READY.
   always_ff @(posedge clk0) begin
      // NOTE: the array has no reset. The zero sweep clears it, which lets
      // the array map onto RAM resources.
      if (!w_ready) begin
         r_mem[r_init_addr] <= '0;
      end else if (w_wr0 && w_addr0_ok) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (sram.wmask0[i]) begin
               r_mem[sram.addr0][i*LANE_WIDTH +: LANE_WIDTH] <=
                  sram.din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Registered read data and collision flag. Deselected ports hold their data.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_dout0     <= '0;
         r_dout1     <= '0;
         r_collision <= 1'b0;
      end else begin
         if (w_rd0) begin
            r_dout0 <= w_mem0;
         end
         if (w_rd1) begin
            r_dout1 <= w_rd1_data;
         end
         r_collision <= w_collision;
      end
   end

   assign sram.dout0     = r_dout0;
   assign sram.dout1     = r_dout1;
   assign sram.collision = r_collision;
   assign sram.init_done = w_ready;

endmodule

// File: doc/sky130_sram_1rw1r_param_model.md
# sky130_sram_1rw1r_param_model

- Parametrised, synthesizable behavioural model of a one-read/write plus one-read-only SRAM on a single clock.
- Generalises the fixed 8x1024 macro with configurable width, depth and write-mask granularity.
- Adds a post-reset zero-initialisation sweep, an explicit read/write collision flag and optional write-to-read bypass.
- Sits wherever a tile instantiates an SRAM macro: simulation, FPGA bring-up, and flows where no hard macro exists.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of NUM_WMASKS.
- NUM_WMASKS, 4, number of write-mask lanes; lane width is DATA_WIDTH/NUM_WMASKS.
- ADDR_WIDTH, 10, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of implemented words; must be ≤ 1<<ADDR_WIDTH.
- clk0  input  1  single clock for both ports; all logic is rising-edge.
- rst0  input  1  asynchronous, active-high reset.
- csb0  input  1  port 0 chip select, active low.
- web0  input  1  port 0 write enable, active low.
- wmask0  input  NUM_WMASKS  per-lane write enable, active high.
- addr0  input  ADDR_WIDTH  port 0 address.
- din0  input  DATA_WIDTH  port 0 write data.
- dout0  output  DATA_WIDTH  port 0 registered read data.
- csb1  input  1  port 1 chip select, active low.
- addr1  input  ADDR_WIDTH  port 1 address.
- dout1  output  DATA_WIDTH  port 1 registered read data.
- init_done  output  1  high once the zero sweep is complete and ports are accepted.
- collision  output  1  one-cycle pulse: the previous cycle had a port 1 read of the address port 0 wrote.

## Operation
- Two states.
  - INIT: entered on reset.
    - An internal counter walks addresses 0..RAM_DEPTH-1, writing all-zero, one word per cycle.
    - csb0 and csb1 are ignored (treated as high).
    - After the write at address RAM_DEPTH-1, the block moves to READY.
  - READY: normal operation; it remains there until the next reset.
- Port 0 write (csb0=0, web0=0): lane i of mem[addr0] takes din0 lane i only where wmask0[i]=1. dout0 holds its previous value.
- Port 0 read (csb0=0, web0=1): dout0 ← mem[addr0].
- Port 1 read (csb1=0): dout1 ← mem[addr1].
- Deselected port: its dout holds its value.
- Address ≥ RAM_DEPTH:
  - Writes are dropped.
  - Reads return all-zero.
  - collision is never raised.
- Collision condition: csb0=0, web0=0, csb1=0, addr0==addr1, address < RAM_DEPTH.
  - collision is registered high for exactly one cycle.
  - dout1 value is set by the Configuration section.
- Reset mid-operation, at any cycle:
  - State returns to INIT and the counter returns to 0.
  - Memory is re-swept to zero.
  - An in-flight write is not guaranteed to land.

## Timing
- Read latency is 1 cycle: an address sampled at edge N appears on dout at edge N (registered) and is valid for all of cycle N+1.
- A write is visible to any read issued on the following edge.
- INIT lasts exactly RAM_DEPTH cycles after rst0 deasserts. init_done rises on the edge that completes the last sweep write.
- Values while rst0 is high: dout0=0, dout1=0, init_done=0, collision=0.
- Throughput: one access per port per cycle, with no stall path.

## Configuration
- Macro: SRAM_BYPASS_EN.
- Defined: on a collision, dout1 returns the merged word.
  - Lanes with wmask0=1 take din0.
  - Other lanes take the old contents.
- Undefined: on a collision, dout1 returns the old contents of the word (read-before-write).
- collision pulses identically in both builds.

## Test plan
- Reset then idle: init_done stays 0 for 1024 cycles and rises on cycle 1024. A read of address 1023 then returns 0x00000000.
- Masked write, default parameters:
  - Write 0xAABBCCDD to address 5 with wmask0=4'b1111.
  - Then write 0x11223344 to address 5 with wmask0=4'b0101.
  - A port 1 read of address 5 returns 0xAA22CC44.
- Collision:
  - Address 7 holds 0x0; port 0 writes 0xDEADBEEF to address 7 (mask 1111) while port 1 reads address 7.
  - collision=1 for one cycle.
  - dout1=0xDEADBEEF with SRAM_BYPASS_EN, 0x00000000 without it.
- Simultaneous reads: port 0 reads address 3 (0x33) and port 1 reads address 4 (0x44) in the same cycle; both are valid the next cycle. Deselecting both keeps 0x33/0x44 on the outputs.
- RAM_DEPTH=600, ADDR_WIDTH=10:
  - A write of 0xFFFFFFFF to address 700 is dropped; a read of address 700 returns 0.
  - A read of address 599 after the sweep returns 0; INIT lasts 600 cycles.
- Mid-operation reset: write 0x12345678 to address 9, assert rst0 for 2 cycles during READY. Required response:
  - Outputs go to 0 immediately.
  - init_done rises 1024 cycles after deassertion.
  - Address 9 then reads 0.
